int_ctrl_riscv: RTL and testbench

Parametrised interrupt controller feeding the decoder's trap path. It accepts `N_IRQ` external interrupt lines, each configured as rising-edge or level sensitive. It masks pending lines with per-line and global enables, selects the highest-priority line, and issues a single-cycle trap request carrying `mcause`. It then holds off further traps until the core retires `mret` (`int_rst_i`). It sits between the platform interrupt sources and the decoder/CSR unit, and replaces the single-line `INT` edge detector.

---
 rtl/int_ctrl_riscv_pkg.sv | 22 ++
 rtl/int_ctrl_riscv_if.sv | 27 ++
 rtl/int_ctrl_riscv_prio_enc.sv | 18 +
 rtl/int_ctrl_riscv.sv | 94 +++++++++
 tb/tb_int_ctrl_riscv.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_riscv_pkg.sv
// Shared types and constants for the interrupt controller.
package riscv_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        HANDLER = 2'd2
    } int_state_t;

    localparam int MCAUSE_INT_BIT = 31;
    localparam int DEF_CAUSE_BASE = 16;

    // Build an interrupt-flavoured mcause value from a 5-bit cause code.
    function automatic logic [31:0] mk_mcause(input logic [4:0] cause);
        logic [31:0] m;
        m                 = '0;
        m[MCAUSE_INT_BIT] = 1'b1;
        m[4:0]            = cause;
        return m;
    endfunction

endpackage

// File: rtl/int_ctrl_riscv_if.sv
// Bundle of interrupt lines, CSR controls and trap outputs.
interface int_ctrl_riscv_if #(
    parameter int N_IRQ = 16
);
    logic [N_IRQ-1:0] irq_i;
    logic [N_IRQ-1:0] mie_i;
    logic             mstatus_mie_i;
    logic             enpc_i;
    logic             int_rst_i;
    logic             int_o;
    logic [31:0]      mcause_o;
    logic [N_IRQ-1:0] claim_o;
    logic [N_IRQ-1:0] pending_o;
    logic             busy_o;

    // Controller side.
    modport slave (
        input  irq_i, mie_i, mstatus_mie_i, enpc_i, int_rst_i,
        output int_o, mcause_o, claim_o, pending_o, busy_o
    );

    // Platform / core side.
    modport master (
        output irq_i, mie_i, mstatus_mie_i, enpc_i, int_rst_i,
        input  int_o, mcause_o, claim_o, pending_o, busy_o
    );
endinterface

// File: rtl/int_ctrl_riscv_prio_enc.sv
// Lowest-index-first priority encoder, purely combinational.
module int_prio_enc #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    // Scan from the top so the lowest set index is written last and wins.
    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
    end
endmodule

// File: rtl/int_ctrl_riscv.sv
// Interrupt controller: edge/level capture, masking, priority select and
// a one-trap-at-a-time FSM that waits for mret before the next trap.
module int_ctrl_riscv
    import riscv_int_pkg::*;
#(
    parameter int               N_IRQ      = 16,
    parameter logic [N_IRQ-1:0] EDGE_SENS  = '1,
    parameter int               CAUSE_BASE = DEF_CAUSE_BASE
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    int_ctrl_riscv_if.slave bus
);
    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    int_state_t       state, state_d;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] pending, pending_d;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] claim_clr;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    id_q;
    logic [31:0]      mcause_q;
    logic [4:0]       cause_d;
    logic             take;

    // Masks are applied to the registered pending vector, so a mask change
    // gates the very edge on which it is sampled.
    assign eligible = pending & bus.mie_i & {N_IRQ{bus.mstatus_mie_i}};

    int_prio_enc #(.N(N_IRQ), .IW(IW)) u_prio (
        .vec_i   (eligible),
        .valid_o (win_vld),
        .idx_o   (win_idx)
    );

    assign cause_d   = 5'(CAUSE_BASE + int'(win_idx));
    assign claim_clr = take ? (N_IRQ'(1) << win_idx) : '0;

    // Per-line capture: edge lines latch until claimed (a fresh rise beats
    // the claim), level lines simply follow the registered input.
    for (genvar k = 0; k < N_IRQ; k++) begin : g_line
        if (EDGE_SENS[k]) begin : g_edge
            assign pending_d[k] = (bus.irq_i[k] & ~irq_prev[k])
                                | (pending[k] & ~claim_clr[k]);
        end else begin : g_level
            assign pending_d[k] = bus.irq_i[k];
        end
    end

    // Next-state: one trap, a single TRAP cycle, then wait for mret.
    always_comb begin
        state_d = state;
        take    = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld && bus.enpc_i) begin
                    take    = 1'b1;
                    state_d = TRAP;
                end
            end
            TRAP:    state_d = HANDLER;
            HANDLER: if (bus.int_rst_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, capture registers, and the winner/cause latched on trap entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            irq_prev <= '0;
            pending  <= '0;
            id_q     <= '0;
            mcause_q <= '0;
        end else begin
            state    <= state_d;
            irq_prev <= bus.irq_i;
            pending  <= pending_d;
            if (take) begin
                id_q     <= win_idx;
                mcause_q <= mk_mcause(cause_d);
            end
        end
    end

    assign bus.int_o     = (state == TRAP);
    assign bus.claim_o   = (state == TRAP) ? (N_IRQ'(1) << id_q) : '0;
    assign bus.busy_o    = (state != IDLE);
    assign bus.pending_o = pending;
    assign bus.mcause_o  = mcause_q;

endmodule

// File: tb/tb_int_ctrl_riscv.sv
// Directed scenarios plus a random phase, every cycle compared against a
// behavioural model of the controller.
module tb_int_ctrl_riscv;
    localparam int N = 16;
    localparam logic [N-1:0] ES = 16'hFFFD;   // line 1 is level sensitive

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int_ctrl_riscv_if #(.N_IRQ(N)) bus ();

    int_ctrl_riscv #(.N_IRQ(N), .EDGE_SENS(ES), .CAUSE_BASE(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit [N-1:0] es_v;
    bit [N-1:0] m_pend, m_prev;
    bit         m_busy, m_pulse;
    int         m_win;
    bit [31:0]  m_mcause;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_busy = 0; m_pulse = 0; m_win = 0; m_mcause = '0;
    endtask

    // One clock edge of the controller's documented behaviour.
    task automatic model_step();
        bit [N-1:0] elig, np;
        int w;
        bit take;
        elig = m_pend & bus.mie_i & {N{bus.mstatus_mie_i}};
        w = -1;
        for (int k = 0; k < N; k++) if (elig[k] && w < 0) w = k;
        take = !m_busy && (w >= 0) && bus.enpc_i;
        for (int k = 0; k < N; k++) begin
            if (es_v[k])
                np[k] = (bus.irq_i[k] && !m_prev[k]) ? 1'b1 :
                        ((take && w == k) ? 1'b0 : m_pend[k]);
            else
                np[k] = bus.irq_i[k];
        end
        if (take) begin
            m_busy = 1; m_pulse = 1; m_win = w;
            m_mcause = 32'h8000_0000 | 32'(16 + w);
        end else if (m_pulse) begin
            m_pulse = 0;
        end else if (m_busy && bus.int_rst_i) begin
            m_busy = 0;
        end
        m_pend = np;
        m_prev = bus.irq_i;
    endtask

    task automatic check_all();
        chk("int_o",   bus.int_o,     32'(m_pulse));
        chk("claim",   bus.claim_o,   m_pulse ? (32'(1) << m_win) : 32'd0);
        chk("pending", bus.pending_o, 32'(m_pend));
        chk("busy",    bus.busy_o,    32'(m_busy));
        chk("mcause",  bus.mcause_o,  m_mcause);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    // Cycles until int_o is seen, or -1 if the bound expires.
    task automatic wait_int(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (bus.int_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic mret();
        bus.int_rst_i = 1'b1;
        cyc();
        bus.int_rst_i = 1'b0;
    endtask

    initial begin
        int n;
        es_v = ES;
        bus.irq_i = '0; bus.mie_i = '0; bus.mstatus_mie_i = 1'b0;
        bus.enpc_i = 1'b0; bus.int_rst_i = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_int", bus.int_o, 0);
        chk("rst_mcause", bus.mcause_o, 0);
        rst_n = 1'b1;
        cyc(); cyc();

        // Single edge on line 3.
        bus.mie_i = 16'h0008; bus.mstatus_mie_i = 1'b1; bus.enpc_i = 1'b1;
        bus.irq_i = 16'h0008;
        cyc();
        chk("s1_pend3", bus.pending_o[3], 1);
        cyc();
        chk("s1_int", bus.int_o, 1);
        chk("s1_mcause", bus.mcause_o, 32'h8000_0013);
        chk("s1_claim", bus.claim_o, 16'h0008);
        chk("s1_clr3", bus.pending_o[3], 0);
        cyc();
        chk("s1_pulse_end", bus.int_o, 0);
        bus.irq_i = '0;
        mret();
        chk("s1_idle", bus.busy_o, 0);

        // Lines 5 and 2 together: 2 first, then 5 after mret.
        bus.mie_i = 16'hFFFF;
        bus.irq_i = 16'h0024;
        wait_int(4, n);
        chk("s2_lat", n, 2);
        chk("s2_mcause_a", bus.mcause_o, 32'h8000_0012);
        cyc(); cyc(); cyc();
        bus.irq_i = '0;
        mret();
        wait_int(5, n);
        chk("s2_lat_b", n, 1);
        chk("s2_mcause_b", bus.mcause_o, 32'h8000_0015);
        cyc();
        mret();

        // enpc_i low holds off a pending line 0.
        bus.enpc_i = 1'b0;
        bus.irq_i = 16'h0001;
        repeat (10) cyc();
        chk("s3_pend0", bus.pending_o[0], 1);
        chk("s3_noint", bus.int_o, 0);
        bus.enpc_i = 1'b1;
        cyc();
        chk("s3_int", bus.int_o, 1);
        chk("s3_mcause", bus.mcause_o, 32'h8000_0010);
        bus.irq_i = '0;
        cyc();
        mret();

        // Level line 1.
        bus.mie_i = 16'h0002;
        bus.irq_i = 16'h0002;
        wait_int(4, n);
        chk("s4_lat", n, 2);
        chk("s4_mcause", bus.mcause_o, 32'h8000_0011);
        cyc(); cyc();
        mret();
        wait_int(3, n);
        chk("s4_retrap", n, 1);
        bus.irq_i = '0;
        cyc();
        mret();
        wait_int(6, n);
        chk("s4_no_retrap", n, -1);
        bus.mie_i = '0;
        bus.irq_i = 16'h0002;
        cyc(); cyc();
        chk("s4_masked_pend", bus.pending_o[1], 1);
        repeat (4) cyc();
        chk("s4_masked_idle", bus.busy_o, 0);
        bus.irq_i = '0;
        cyc();

        // mret during TRAP is ignored; line 4 waits for the real mret.
        bus.mie_i = 16'hFFFF;
        bus.irq_i = 16'h0080;
        wait_int(4, n);
        chk("s5_lat", n, 2);
        bus.int_rst_i = 1'b1;
        cyc();
        bus.int_rst_i = 1'b0;
        chk("s5_still_busy", bus.busy_o, 1);
        bus.irq_i = 16'h0090;
        repeat (4) cyc();
        chk("s5_pend4", bus.pending_o[4], 1);
        chk("s5_no_nest", bus.int_o, 0);
        mret();
        wait_int(3, n);
        chk("s5_lat_b", n, 1);
        chk("s5_mcause", bus.mcause_o, 32'h8000_0014);
        bus.irq_i = '0;
        cyc();

        // Reset in HANDLER with line 6 pending; line 9 held across release.
        bus.irq_i = 16'h0040;
        cyc();
        chk("s6_pend6", bus.pending_o[6], 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("s6_rst_busy", bus.busy_o, 0);
        chk("s6_rst_pend", bus.pending_o, 0);
        bus.irq_i = 16'h0200;
        cyc(); cyc();
        rst_n = 1'b1;
        wait_int(4, n);
        chk("s6_lat", n, 2);
        chk("s6_mcause", bus.mcause_o, 32'h8000_0019);
        bus.irq_i = '0;
        cyc();
        mret();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                bus.irq_i = bus.irq_i ^ N'(32'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 15) == 0) bus.mie_i = N'($urandom);
            bus.mstatus_mie_i = ($urandom_range(0, 9) != 0);
            bus.enpc_i        = ($urandom_range(0, 4) != 0);
            bus.int_rst_i     = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
